// File: rtl/dmem_access_ctrl_if.sv
// Bus bundle between the MEM-stage pipeline, the access controller and the
// word-addressed data memory.
//   Pipeline side : req_read, req_write, func3, addr, wdata -> controller
//                   rdata, stall, access_fault              <- controller
//   Memory side   : mem_read, mem_write, mem_addr, mem_wdata <- controller
//                   mem_rdata, mem_busywait                  -> controller
// slave  : the controller's view.
// master : the view of the environment (pipeline plus memory) around it.
interface dmem_access_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 32
);
  logic                  req_read;
  logic                  req_write;
  logic [2:0]            func3;
  logic [ADDR_WIDTH-1:0] addr;
  logic [31:0]           wdata;
  logic [31:0]           rdata;
  logic                  stall;
  logic                  access_fault;
  logic                  mem_read;
  logic                  mem_write;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;
  logic [31:0]           mem_rdata;
  logic                  mem_busywait;

  modport slave (
    input  req_read, req_write, func3, addr, wdata, mem_rdata, mem_busywait,
    output rdata, stall, access_fault, mem_read, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output req_read, req_write, func3, addr, wdata, mem_rdata, mem_busywait,
    input  rdata, stall, access_fault, mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data memory access controller.
// Sequences loads/stores onto a word-addressed memory with a busywait
// handshake, extracts and extends load lanes, turns sb/sh into a
// read-modify-write so memory only sees full-word writes, stalls the
// pipeline while an access is in flight and flags misaligned, illegal and
// timed-out accesses.
// Ports:
//   CLK   : clock, all state updates on posedge
//   RESET : synchronous, active-high
//   bus   : dmem_access_ctrl_if.slave (pipeline request/response and
//           memory strobe/handshake signals)
module dmem_access_ctrl #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned WAIT_LIMIT = 255
) (
  input  logic                  CLK,
  input  logic                  RESET,
  dmem_access_ctrl_if.slave     bus
);

  typedef enum logic [2:0] {IDLE, RD, RMW_RD, WR, DONE} state_t;

  localparam int unsigned  CW    = $clog2(WAIT_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(WAIT_LIMIT);

  state_t        state_q, state_d;
  logic [CW-1:0] wait_q;
  logic [31:0]   rdata_q, merge_q;
  logic [31:0]   load_word, merge_word;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic          is_half, is_word, req_any, illegal, misaligned;
  logic          active, timeout;
  logic          stall, fault, mem_read, mem_write;

  // request decode (only acted upon in IDLE)
  always_comb begin
    is_half    = (bus.func3[1:0] == 2'b01);
    is_word    = (bus.func3[1:0] == 2'b10);
    req_any    = bus.req_read | bus.req_write;
    illegal    = (bus.req_read & bus.req_write)
               | (bus.req_read & ((bus.func3 == 3'b011) || (bus.func3[2:1] == 2'b11)))
               | (bus.req_write & bus.func3[2]);
    misaligned = (is_half & bus.addr[0]) | (is_word & (bus.addr[1:0] != 2'b00));
  end

  // load lane extraction and sub-word store merge
  always_comb begin
    byte_sel = bus.mem_rdata[{bus.addr[1:0], 3'b000} +: 8];
    half_sel = bus.addr[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    case (bus.func3)
      3'b000:  load_word = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  load_word = {24'h000000, byte_sel};
      3'b001:  load_word = {{16{half_sel[15]}}, half_sel};
      3'b101:  load_word = {16'h0000, half_sel};
      default: load_word = bus.mem_rdata;
    endcase
    merge_word = bus.mem_rdata;
    if (bus.func3[1:0] == 2'b00)
      merge_word[{bus.addr[1:0], 3'b000} +: 8] = bus.wdata[7:0];
    else
      merge_word[{bus.addr[1], 4'b0000} +: 16] = bus.wdata[15:0];
  end

  assign active  = (state_q == RD) || (state_q == RMW_RD) || (state_q == WR);
  // abort takes priority over a transfer that would complete the same cycle
  assign timeout = active && (wait_q == LIMIT);

  always_comb begin
    state_d   = state_q;
    stall     = 1'b0;
    fault     = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_any) begin
          if (illegal || misaligned) begin
            fault = 1'b1;
          end else begin
            stall = 1'b1;
            if (bus.req_read)  state_d = RD;
            else if (is_word)  state_d = WR;
            else               state_d = RMW_RD;
          end
        end
      end
      RD, RMW_RD: begin
        stall = 1'b1;
        if (timeout) begin
          fault   = 1'b1;
          state_d = DONE;
        end else begin
          mem_read = 1'b1;
          if (!bus.mem_busywait) state_d = (state_q == RD) ? DONE : WR;
        end
      end
      WR: begin
        stall = 1'b1;
        if (timeout) begin
          fault   = 1'b1;
          state_d = DONE;
        end else begin
          mem_write = 1'b1;
          if (!bus.mem_busywait) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      rdata_q <= '0;
      merge_q <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q)
        wait_q <= '0;
      else if (active && bus.mem_busywait && (wait_q != LIMIT))
        wait_q <= wait_q + 1'b1;
      if ((state_q == RD) && !timeout && !bus.mem_busywait)
        rdata_q <= load_word;
      if ((state_q == RMW_RD) && !timeout && !bus.mem_busywait)
        merge_q <= merge_word;
    end
  end

  assign bus.rdata        = rdata_q;
  assign bus.stall        = stall;
  assign bus.access_fault = fault;
  assign bus.mem_read     = mem_read;
  assign bus.mem_write    = mem_write;
  assign bus.mem_addr     = {bus.addr[ADDR_WIDTH-1:2], 2'b00};
  assign bus.mem_wdata    = is_word ? bus.wdata : merge_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Scoreboard bench for dmem_access_ctrl: the driver pushes the reference
// model's expected outcome for each request, a negedge monitor pops and
// compares on every fault pulse or access completion.
module tb_dmem_access_ctrl;
  localparam int unsigned LIMIT = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmem_access_ctrl_if #(.ADDR_WIDTH(32)) bus ();

  dmem_access_ctrl #(.ADDR_WIDTH(32), .WAIT_LIMIT(LIMIT)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  // memory responder state
  logic [31:0] dmem [64];
  int          fixed_wait = 0;   // <0 selects random 0..2 wait cycles
  bit          stuck = 1'b0;
  int          busy_cnt = 0;
  int          wait_target = 0;
  int          reads_done = 0;
  int          writes_done = 0;

  // reference model: byte-addressed view of 0x100..0x1FF
  logic [7:0] ref_bytes [256];

  typedef struct {
    bit          fault;
    bit          fault_stall;
    bit          is_load;
    bit          is_store;
    logic [31:0] exp_rdata;
    logic [5:0]  idx;
    logic [31:0] exp_word;
  } exp_t;
  exp_t sb_q[$];

  function automatic logic [31:0] init_word(input int i);
    return (i == 0) ? 32'h8899AABB : 32'(32'h9E3779B9 * (i + 1));
  endfunction

  function automatic logic [31:0] ref_word(input int i);
    return {ref_bytes[4*i+3], ref_bytes[4*i+2], ref_bytes[4*i+1], ref_bytes[4*i]};
  endfunction

  function automatic int op_size(input bit rd, input bit wr, input logic [2:0] f3);
    if (rd && wr) return 0;
    if (rd) begin
      case (f3)
        3'b000, 3'b100: return 1;
        3'b001, 3'b101: return 2;
        3'b010:         return 4;
        default:        return 0;
      endcase
    end
    if (wr) begin
      case (f3)
        3'b000:  return 1;
        3'b001:  return 2;
        3'b010:  return 4;
        default: return 0;
      endcase
    end
    return 0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  assign bus.mem_rdata    = dmem[bus.mem_addr[7:2]];
  assign bus.mem_busywait = stuck || ((bus.mem_read || bus.mem_write) && (busy_cnt < wait_target));

  initial begin
    for (int i = 0; i < 64; i++) dmem[i] = init_word(i);
    forever begin
      @(posedge clk);
      if (bus.mem_read || bus.mem_write) begin
        if (!bus.mem_busywait) begin
          if (bus.mem_write) begin
            dmem[bus.mem_addr[7:2]] <= bus.mem_wdata;
            writes_done <= writes_done + 1;
          end else begin
            reads_done <= reads_done + 1;
          end
          busy_cnt    <= 0;
          wait_target <= (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, 2));
        end else begin
          busy_cnt <= busy_cnt + 1;
        end
      end else begin
        busy_cnt    <= 0;
        wait_target <= (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, 2));
      end
    end
  end

  // monitor
  initial begin
    bit          ps = 1'b0, pf = 1'b0, pbusy = 1'b0, pwr = 1'b0;
    logic [31:0] pa = '0, pw = '0;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (rst) begin
        ps = 1'b0; pf = 1'b0; pbusy = 1'b0;
      end else begin
        if (bus.mem_read || bus.mem_write)
          check("strobe_exclusive", 32'(bus.mem_read & bus.mem_write), 32'd0);
        if (pbusy && (bus.mem_read || bus.mem_write)) begin
          check("mem_addr_stable", bus.mem_addr, pa);
          if (pwr) check("mem_wdata_stable", bus.mem_wdata, pw);
        end
        if (bus.access_fault) begin
          if (sb_q.size() == 0) begin
            check("unexpected_fault", 32'd1, 32'd0);
          end else begin
            e = sb_q.pop_front();
            check("fault_expected", 32'd1, 32'(e.fault));
            check("fault_stall", 32'(bus.stall), 32'(e.fault_stall));
            check("fault_no_strobe", 32'({bus.mem_read, bus.mem_write}), 32'd0);
          end
        end else if (ps && !bus.stall && !pf) begin
          if (sb_q.size() == 0) begin
            check("unexpected_done", 32'd1, 32'd0);
          end else begin
            e = sb_q.pop_front();
            check("done_not_fault", 32'd0, 32'(e.fault));
            if (e.is_load)  check("load_rdata", bus.rdata, e.exp_rdata);
            if (e.is_store) check("store_word", dmem[e.idx], e.exp_word);
          end
        end
        ps    = bus.stall;
        pf    = bus.access_fault;
        pbusy = (bus.mem_read || bus.mem_write) && bus.mem_busywait;
        pwr   = bus.mem_write;
        pa    = bus.mem_addr;
        pw    = bus.mem_wdata;
      end
    end
  end

  task automatic issue(input bit rd, input bit wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd,
                       input bit timeout_exp, output int stalls);
    exp_t        e;
    int          sz;
    logic [31:0] v;
    bit          done;
    sz = op_size(rd, wr, f3);
    e.fault = 1'b0; e.fault_stall = 1'b0; e.is_load = 1'b0; e.is_store = 1'b0;
    e.exp_rdata = '0; e.idx = a[7:2]; e.exp_word = '0;
    if (sz == 0 || (a % sz) != 0) begin
      e.fault = 1'b1;
    end else if (timeout_exp) begin
      e.fault = 1'b1; e.fault_stall = 1'b1;
    end else if (rd) begin
      v = '0;
      for (int i = 0; i < sz; i++) v |= 32'(ref_bytes[int'(a[7:0]) + i]) << (8 * i);
      if (!f3[2] && sz < 4 && v[8*sz-1]) v |= ~((32'h1 << (8 * sz)) - 32'h1);
      e.is_load = 1'b1; e.exp_rdata = v;
    end else begin
      for (int i = 0; i < sz; i++) ref_bytes[int'(a[7:0]) + i] = wd[8*i +: 8];
      e.is_store = 1'b1; e.exp_word = ref_word(int'(a[7:2]));
    end
    sb_q.push_back(e);
    @(posedge clk); #1;
    bus.req_read = rd; bus.req_write = wr; bus.func3 = f3; bus.addr = a; bus.wdata = wd;
    stalls = 0; done = 1'b0;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk);
      if (bus.stall) stalls++;
      else done = 1'b1;
    end
    if (!done) check("request_completes", 32'd0, 32'd1);
    @(posedge clk); #1;
    bus.req_read = 1'b0; bus.req_write = 1'b0;
  endtask

  initial begin
    int          st;
    int          r0, w0, sz, r;
    bit          rd, wr, seen;
    logic [2:0]  f3;
    logic [31:0] a, prev;
    logic [2:0]  ld_f3 [5];
    logic [31:0] ld_a [6];
    logic [31:0] ld_exp [6];
    logic [2:0]  ld_fn [6];

    for (int i = 0; i < 64; i++)
      for (int b = 0; b < 4; b++) ref_bytes[4*i+b] = init_word(i) >> (8 * b);

    rst = 1'b1;
    bus.req_read = 1'b0; bus.req_write = 1'b0; bus.func3 = 3'b000;
    bus.addr = 32'h100; bus.wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_stall", 32'(bus.stall), 32'd0);
    check("reset_mem_read", 32'(bus.mem_read), 32'd0);
    check("reset_mem_write", 32'(bus.mem_write), 32'd0);
    check("reset_fault", 32'(bus.access_fault), 32'd0);
    check("reset_rdata", bus.rdata, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // directed loads on 0x8899AABB at 0x100, zero-wait memory
    ld_fn  = '{3'b000, 3'b100, 3'b000, 3'b001, 3'b101, 3'b010};
    ld_a   = '{32'h103, 32'h102, 32'h100, 32'h102, 32'h100, 32'h100};
    ld_exp = '{32'hFFFFFF88, 32'h00000099, 32'hFFFFFFBB,
               32'hFFFF8899, 32'h0000AABB, 32'h8899AABB};
    for (int i = 0; i < 6; i++) begin
      issue(1'b1, 1'b0, ld_fn[i], ld_a[i], '0, 1'b0, st);
      check("load_const", bus.rdata, ld_exp[i]);
      check("load_stall_cycles", 32'(st), 32'd2);
    end

    // sub-word stores as read-modify-write
    r0 = reads_done; w0 = writes_done;
    issue(1'b0, 1'b1, 3'b000, 32'h101, 32'h12345677, 1'b0, st);
    check("sb_reads", 32'(reads_done - r0), 32'd1);
    check("sb_writes", 32'(writes_done - w0), 32'd1);
    check("sb_stall_cycles", 32'(st), 32'd3);
    check("sb_word", dmem[0], 32'h889977BB);
    issue(1'b0, 1'b1, 3'b001, 32'h102, 32'h0000CAFE, 1'b0, st);
    check("sh_stall_cycles", 32'(st), 32'd3);
    check("sh_word", dmem[0], 32'hCAFE77BB);
    issue(1'b0, 1'b1, 3'b010, 32'h10C, 32'hA5A55A5A, 1'b0, st);
    check("sw_stall_cycles", 32'(st), 32'd2);
    check("sw_word", dmem[3], 32'hA5A55A5A);

    // three busy cycles in RD
    fixed_wait = 3;
    issue(1'b1, 1'b0, 3'b010, 32'h100, '0, 1'b0, st);
    check("wait3_stall_cycles", 32'(st), 32'd5);
    check("wait3_rdata", bus.rdata, 32'hCAFE77BB);
    fixed_wait = 0;

    // busywait stuck: abort after LIMIT busy cycles, rdata kept
    stuck = 1'b1;
    prev  = bus.rdata;
    issue(1'b1, 1'b0, 3'b010, 32'h104, '0, 1'b1, st);
    check("timeout_stall_cycles", 32'(st), 32'(LIMIT + 2));
    check("timeout_rdata_kept", bus.rdata, prev);
    stuck = 1'b0;

    // illegal / misaligned requests
    issue(1'b1, 1'b0, 3'b010, 32'h102, '0, 1'b0, st);
    check("lw_misaligned_stall", 32'(st), 32'd0);
    issue(1'b0, 1'b1, 3'b001, 32'h101, 32'h1111, 1'b0, st);
    check("sh_misaligned_stall", 32'(st), 32'd0);
    issue(1'b1, 1'b0, 3'b011, 32'h100, '0, 1'b0, st);
    check("load_f3_011_stall", 32'(st), 32'd0);
    issue(1'b1, 1'b1, 3'b010, 32'h100, 32'h2222, 1'b0, st);
    check("rd_wr_stall", 32'(st), 32'd0);
    check("faults_mem_intact", dmem[0], 32'hCAFE77BB);

    // reset while a sw is waiting in WR
    stuck = 1'b1;
    @(posedge clk); #1;
    bus.req_write = 1'b1; bus.func3 = 3'b010; bus.addr = 32'h108; bus.wdata = 32'hDEADBEEF;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (bus.mem_write) seen = 1'b1;
    end
    check("reset_test_reached_wr", 32'(seen), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1; bus.req_write = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midreset_mem_write", 32'(bus.mem_write), 32'd0);
    check("midreset_stall", 32'(bus.stall), 32'd0);
    check("midreset_rdata", bus.rdata, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; stuck = 1'b0;
    check("midreset_word_kept", dmem[2], init_word(2));
    issue(1'b1, 1'b0, 3'b010, 32'h108, '0, 1'b0, st);
    check("post_reset_lw", bus.rdata, init_word(2));

    // randomized traffic with random memory waits
    fixed_wait = -1;
    ld_f3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    for (int n = 0; n < 300; n++) begin
      r  = int'($urandom_range(0, 9));
      rd = 1'b0; wr = 1'b0;
      if (r <= 4) begin
        rd = 1'b1; f3 = ld_f3[$urandom_range(0, 4)];
      end else if (r <= 7) begin
        wr = 1'b1; f3 = 3'($urandom_range(0, 2));
      end else if (r == 8) begin
        rd = 1'b1; f3 = ($urandom_range(0, 2) == 0) ? 3'b011 : 3'($urandom_range(6, 7));
      end else begin
        wr = 1'b1; rd = 1'($urandom_range(0, 1)); f3 = rd ? 3'b010 : 3'($urandom_range(4, 7));
      end
      sz = (f3[1:0] == 2'b10) ? 4 : (f3[1:0] == 2'b01) ? 2 : 1;
      a  = 32'h100 | 32'($urandom_range(0, 255));
      if ($urandom_range(0, 9) != 0) a = a & ~32'(sz - 1);
      issue(rd, wr, f3, a, $urandom, 1'b0, st);
    end

    repeat (4) @(negedge clk);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    for (int i = 0; i < 64; i++) check("final_mem", dmem[i], ref_word(i));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end
endmodule
